// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: ALU op codes, opcodes, operand selects and the
// immediate generator used by the issue stage.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // IMM_SH is the zero-extended shamt field of OP-IMM shifts
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_type_e;
    typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srca_sel_e;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} srcb_sel_e;

    typedef struct packed {
        alu_op_e     alu_op;
        srca_sel_e   srca_sel;
        srcb_sel_e   srcb_sel;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        legal;
    } dec_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_e t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_SH:  return {27'b0, i[24:20]};
            default: return 32'b0;
        endcase
    endfunction

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/insn_decode.sv
// Pure combinational RV32I decode: ALU op, operand selects, immediate and
// control flags for one instruction word.
module insn_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    imm_type_e imm_t;

    always_comb begin
        dec.alu_op    = ALU_ADD;
        dec.srca_sel  = SRCA_RS1;
        dec.srcb_sel  = SRCB_IMM;
        dec.reg_write = 1'b0;
        dec.mem_read  = 1'b0;
        dec.mem_write = 1'b0;
        dec.is_branch = 1'b0;
        dec.uses_rs1  = 1'b0;
        dec.uses_rs2  = 1'b0;
        dec.legal     = 1'b1;
        imm_t         = IMM_I;
        case (instr[6:0])
            OPC_OP: begin
                dec.alu_op    = alu_from_f3(instr[14:12], instr[30]);
                dec.srcb_sel  = SRCB_RS2;
                dec.reg_write = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
            end
            OPC_OPIMM: begin
                // only the shift-right encoding treats instr[30] as an op select
                dec.alu_op    = alu_from_f3(instr[14:12], (instr[14:12] == 3'b101) & instr[30]);
                imm_t         = (instr[13:12] == 2'b01) ? IMM_SH : IMM_I;
                dec.reg_write = 1'b1;
                dec.uses_rs1  = 1'b1;
            end
            OPC_LUI: begin
                dec.srca_sel  = SRCA_ZERO;
                imm_t         = IMM_U;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.srca_sel  = SRCA_PC;
                imm_t         = IMM_U;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.uses_rs1  = 1'b1;
            end
            OPC_STORE: begin
                imm_t         = IMM_S;
                dec.mem_write = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                case (instr[14:13])
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: dec.alu_op = ALU_SUB;
                endcase
                dec.srcb_sel  = SRCB_RS2;
                imm_t         = IMM_B;
                dec.is_branch = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.srca_sel  = SRCA_PC;
                dec.srcb_sel  = SRCB_FOUR;
                imm_t         = (instr[3]) ? IMM_J : IMM_I;
                dec.reg_write = 1'b1;
                dec.uses_rs1  = ~instr[3];
            end
            default: dec.legal = 1'b0;
        endcase
        dec.imm = gen_imm(instr, imm_t);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand select, load-use bubble and issue slot.
// Optional ILLEGAL_INSN_EN issues unknown opcodes flagged on illegal_instr.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [W-1:0]  pc,
    output logic [RA-1:0] rs1_addr,
    output logic [RA-1:0] rs2_addr,
    input  logic [W-1:0]  rs1_data,
    input  logic [W-1:0]  rs2_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  SrcA,
    output logic [W-1:0]  SrcB,
    output logic [3:0]    ALUCtrl,
    output logic [RA-1:0] rd_addr,
    output logic          reg_write,
    output logic          mem_read,
    output logic          mem_write,
    output logic [W-1:0]  store_data,
    output logic [2:0]    br_funct3,
`ifdef ILLEGAL_INSN_EN
    output logic          illegal_instr,
`endif
    output logic          is_branch
);

    dec_t           dec;
    logic [W-1:0]   srca_nxt;
    logic [W-1:0]   srcb_nxt;
    logic [RA-1:0]  rd_nxt;
    logic           slot_load;
    logic           hazard;
    logic           accept;
    logic           issue_illegal;

    insn_decode u_dec (.instr(instr), .dec(dec));

    assign rs1_addr = RA'(instr[19:15]);
    assign rs2_addr = RA'(instr[24:20]);
    assign rd_nxt   = RA'(instr[11:7]);

`ifdef ILLEGAL_INSN_EN
    assign issue_illegal = 1'b1;
`else
    assign issue_illegal = 1'b0;
`endif

    // Handshake: an instruction moves in when in_valid & in_ready; the slot
    // hands off to EX when out_valid & out_ready, and may refill in that same
    // cycle. While out_valid & ~out_ready every slot output holds steady.
    assign slot_load = ~out_valid | out_ready;
    assign hazard    = out_valid & mem_read & (rd_addr != '0) &
                       ((dec.uses_rs1 & (rd_addr == rs1_addr)) |
                        (dec.uses_rs2 & (rd_addr == rs2_addr)));
    assign in_ready  = ~rst & (flush | (slot_load & ~hazard));
    assign accept    = in_valid & slot_load & ~hazard;

    always_comb begin
        case (dec.srca_sel)
            SRCA_PC:   srca_nxt = pc;
            SRCA_ZERO: srca_nxt = '0;
            default:   srca_nxt = rs1_data;
        endcase
        case (dec.srcb_sel)
            SRCB_IMM:  srcb_nxt = W'($signed(dec.imm));
            SRCB_FOUR: srcb_nxt = W'(4);
            default:   srcb_nxt = rs2_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            SrcA       <= '0;
            SrcB       <= '0;
            ALUCtrl    <= ALU_ADD;
            rd_addr    <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            store_data <= '0;
            br_funct3  <= '0;
            is_branch  <= 1'b0;
        end else if (flush) begin
            // a concurrent in_valid instruction is consumed and dropped here
            out_valid <= 1'b0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            is_branch <= 1'b0;
        end else if (slot_load) begin
            if (accept && dec.legal) begin
                out_valid  <= 1'b1;
                SrcA       <= srca_nxt;
                SrcB       <= srcb_nxt;
                ALUCtrl    <= dec.alu_op;
                rd_addr    <= rd_nxt;
                reg_write  <= dec.reg_write & (rd_nxt != '0);
                mem_read   <= dec.mem_read;
                mem_write  <= dec.mem_write;
                store_data <= rs2_data;
                br_funct3  <= instr[14:12];
                is_branch  <= dec.is_branch;
            end else if (accept && issue_illegal) begin
                out_valid  <= 1'b1;
                SrcA       <= '0;
                SrcB       <= '0;
                ALUCtrl    <= ALU_ADD;
                rd_addr    <= rd_nxt;
                reg_write  <= 1'b0;
                mem_read   <= 1'b0;
                mem_write  <= 1'b0;
                br_funct3  <= instr[14:12];
                is_branch  <= 1'b0;
            end else begin
                // bubble: empty slot, no side effects downstream
                out_valid <= 1'b0;
                reg_write <= 1'b0;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                is_branch <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_INSN_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            illegal_instr <= 1'b0;
        end else if (slot_load) begin
            illegal_instr <= accept & ~dec.legal;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: per-feature tasks with inline checks plus
// an in-order rd scoreboard on the EX handshake. Honours ILLEGAL_INSN_EN.
module tb_alu_issue_stage;

    localparam int W  = 32;
    localparam int RA = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [W-1:0]  pc;
    logic [RA-1:0] rs1_addr, rs2_addr;
    logic [W-1:0]  rs1_data, rs2_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  SrcA, SrcB;
    logic [3:0]    ALUCtrl;
    logic [RA-1:0] rd_addr;
    logic          reg_write, mem_read, mem_write, is_branch;
    logic [W-1:0]  store_data;
    logic [2:0]    br_funct3;
`ifdef ILLEGAL_INSN_EN
    logic          illegal_instr;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    logic [RA-1:0] exp_q[$];

    alu_issue_stage #(.W(W), .RA(RA)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
        .ALUCtrl(ALUCtrl), .rd_addr(rd_addr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
        .br_funct3(br_funct3),
`ifdef ILLEGAL_INSN_EN
        .illegal_instr(illegal_instr),
`endif
        .is_branch(is_branch)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // scoreboard: every EX handshake must deliver the next expected rd
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL sb_unexpected_issue got rd=%0d exp none", rd_addr);
            end else begin
                logic [RA-1:0] e;
                e = exp_q.pop_front();
                if (rd_addr !== e) begin
                    n_miss++;
                    $display("FAIL sb_rd_order got %0d exp %0d", rd_addr, e);
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // driver tasks
    task automatic drive(input logic [31:0] i, input logic [W-1:0] p,
                         input logic [W-1:0] d1, input logic [W-1:0] d2, output logic rdy);
        instr = i; pc = p; rs1_data = d1; rs2_data = d2; in_valid = 1'b1;
        #1 rdy = in_ready;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL rst_in_ready_low got %b exp 0", in_ready); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_vec++; if ({SrcA, SrcB} !== 64'd0) begin n_miss++; $display("FAIL rst_src got %h/%h exp 0/0", SrcA, SrcB); end
        n_vec++; if ({ALUCtrl, rd_addr, reg_write, mem_read, mem_write, is_branch, br_funct3} !== 16'd0) begin
            n_miss++; $display("FAIL rst_ctrl got alu=%b rd=%0d rw=%b mr=%b mw=%b br=%b f3=%b exp all 0",
                               ALUCtrl, rd_addr, reg_write, mem_read, mem_write, is_branch, br_funct3);
        end
        n_vec++; if (store_data !== 32'd0) begin n_miss++; $display("FAIL rst_store_data got %h exp 0", store_data); end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        out_ready = 1'b1;
        exp_q.push_back(5'd3);
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OP_R), 32'h0, 32'd5, 32'd7, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL b2b_add_ready got %b exp 1", rdy); end
        n_vec++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin n_miss++; $display("FAIL b2b_rs_addr got %0d/%0d exp 1/2", rs1_addr, rs2_addr); end
        n_vec++; if ({out_valid, SrcA, SrcB} !== {1'b1, 32'd5, 32'd7}) begin n_miss++; $display("FAIL b2b_add_ops got v=%b %0d/%0d exp 1 5/7", out_valid, SrcA, SrcB); end
        n_vec++; if ({ALUCtrl, rd_addr, reg_write} !== {4'b0000, 5'd3, 1'b1}) begin n_miss++; $display("FAIL b2b_add_ctrl got alu=%b rd=%0d rw=%b exp 0000 3 1", ALUCtrl, rd_addr, reg_write); end
        exp_q.push_back(5'd4);
        drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4, OP_R), 32'h4, 32'd9, 32'd3, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL b2b_sub_ready got %b exp 1", rdy); end
        n_vec++; if ({out_valid, ALUCtrl, SrcA, SrcB} !== {1'b1, 4'b0001, 32'd9, 32'd3}) begin n_miss++; $display("FAIL b2b_sub got v=%b alu=%b %0d/%0d exp 1 0001 9/3", out_valid, ALUCtrl, SrcA, SrcB); end
        exp_q.push_back(5'd0);
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd0, OP_R), 32'h8, 32'd1, 32'd2, rdy);
        n_vec++; if ({ALUCtrl, reg_write} !== {4'b0011, 1'b0}) begin n_miss++; $display("FAIL b2b_or_x0 got alu=%b rw=%b exp 0011 0", ALUCtrl, reg_write); end
        idle();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_immediates();
        logic rdy;
        out_ready = 1'b1;
        exp_q.push_back(5'd1);
        drive(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OP_I), 32'h10, 32'd0, 32'h55, rdy);
        n_vec++; if ({SrcA, SrcB, ALUCtrl} !== {32'd0, 32'hFFFF_FFFF, 4'b0000}) begin n_miss++; $display("FAIL imm_addi got %h/%h alu=%b exp 0/ffffffff 0000", SrcA, SrcB, ALUCtrl); end
        exp_q.push_back(5'd2);
        drive(enc_i(12'h404, 5'd1, 3'b101, 5'd2, OP_I), 32'h14, 32'h8000_0000, 32'd0, rdy);
        n_vec++; if ({ALUCtrl, SrcB[4:0], SrcA} !== {4'b0111, 5'd4, 32'h8000_0000}) begin n_miss++; $display("FAIL imm_srai got alu=%b sh=%0d a=%h exp 0111 4 80000000", ALUCtrl, SrcB[4:0], SrcA); end
        exp_q.push_back(5'd5);
        drive({20'h12345, 5'd5, 7'b0110111}, 32'h18, 32'hDEAD_BEEF, 32'd0, rdy);
        n_vec++; if ({SrcA, SrcB, ALUCtrl} !== {32'd0, 32'h1234_5000, 4'b0000}) begin n_miss++; $display("FAIL imm_lui got %h/%h alu=%b exp 0/12345000 0000", SrcA, SrcB, ALUCtrl); end
        exp_q.push_back(5'd6);
        drive({20'h00001, 5'd6, 7'b0010111}, 32'h200, 32'd0, 32'd0, rdy);
        n_vec++; if ({SrcA, SrcB} !== {32'h200, 32'h1000}) begin n_miss++; $display("FAIL imm_auipc got %h/%h exp 200/1000", SrcA, SrcB); end
        exp_q.push_back(5'd1);
        drive({20'h00000, 5'd1, 7'b1101111}, 32'h300, 32'd0, 32'd0, rdy);
        n_vec++; if ({SrcA, SrcB, reg_write, ALUCtrl} !== {32'h300, 32'd4, 1'b1, 4'b0000}) begin n_miss++; $display("FAIL imm_jal got %h/%h rw=%b alu=%b exp 300/4 1 0000", SrcA, SrcB, reg_write, ALUCtrl); end
        idle();
    endtask

    task automatic test_branch_store();
        logic rdy;
        out_ready = 1'b1;
        exp_q.push_back(5'd0);
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd0, OP_BR), 32'h40, 32'd3, 32'd4, rdy);
        n_vec++; if ({ALUCtrl, is_branch, reg_write, br_funct3} !== {4'b1001, 1'b1, 1'b0, 3'b110}) begin n_miss++; $display("FAIL br_bltu got alu=%b br=%b rw=%b f3=%b exp 1001 1 0 110", ALUCtrl, is_branch, reg_write, br_funct3); end
        n_vec++; if ({SrcA, SrcB} !== {32'd3, 32'd4}) begin n_miss++; $display("FAIL br_ops got %0d/%0d exp 3/4", SrcA, SrcB); end
        exp_q.push_back(5'd8);
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b010, 5'd8, OP_ST), 32'h44, 32'h100, 32'hCAFE, rdy);
        n_vec++; if ({mem_write, mem_read, reg_write, is_branch} !== 4'b1000) begin n_miss++; $display("FAIL st_flags got mw=%b mr=%b rw=%b br=%b exp 1 0 0 0", mem_write, mem_read, reg_write, is_branch); end
        n_vec++; if ({SrcA, SrcB, store_data} !== {32'h100, 32'd8, 32'hCAFE}) begin n_miss++; $display("FAIL st_ops got %h/%h sd=%h exp 100/8 cafe", SrcA, SrcB, store_data); end
        idle();
    endtask

    task automatic test_load_use();
        logic rdy;
        out_ready = 1'b1;
        exp_q.push_back(5'd4);
        drive(enc_i(12'h000, 5'd1, 3'b010, 5'd4, OP_LD), 32'h80, 32'h1000, 32'd0, rdy);
        n_vec++; if ({out_valid, mem_read, rd_addr, SrcA} !== {1'b1, 1'b1, 5'd4, 32'h1000}) begin n_miss++; $display("FAIL lu_lw got v=%b mr=%b rd=%0d a=%h exp 1 1 4 1000", out_valid, mem_read, rd_addr, SrcA); end
        exp_q.push_back(5'd6);
        drive(enc_r(7'b0, 5'd4, 5'd4, 3'b000, 5'd6, OP_R), 32'h84, 32'd7, 32'd7, rdy);
        n_vec++; if (rdy !== 1'b0) begin n_miss++; $display("FAIL lu_stall_ready got %b exp 0", rdy); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL lu_bubble got %b exp 0", out_valid); end
        drive(enc_r(7'b0, 5'd4, 5'd4, 3'b000, 5'd6, OP_R), 32'h84, 32'd7, 32'd7, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL lu_retry_ready got %b exp 1", rdy); end
        n_vec++; if ({out_valid, rd_addr, ALUCtrl, SrcA} !== {1'b1, 5'd6, 4'b0000, 32'd7}) begin n_miss++; $display("FAIL lu_add_issue got v=%b rd=%0d alu=%b a=%0d exp 1 6 0000 7", out_valid, rd_addr, ALUCtrl, SrcA); end
        exp_q.push_back(5'd4);
        drive(enc_i(12'h000, 5'd1, 3'b010, 5'd4, OP_LD), 32'h88, 32'h2000, 32'd0, rdy);
        exp_q.push_back(5'd7);
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd7, OP_R), 32'h8C, 32'd1, 32'd2, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL lu_no_dep_ready got %b exp 1", rdy); end
        n_vec++; if ({out_valid, rd_addr} !== {1'b1, 5'd7}) begin n_miss++; $display("FAIL lu_no_dep_issue got v=%b rd=%0d exp 1 7", out_valid, rd_addr); end
        idle();
    endtask

    task automatic test_backpressure();
        logic rdy;
        out_ready = 1'b1;
        exp_q.push_back(5'd7);
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd7, OP_R), 32'hA0, 32'd11, 32'd22, rdy);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd8, OP_R), 32'hA4, 32'd33, 32'd44, rdy);
            n_vec++; if (rdy !== 1'b0) begin n_miss++; $display("FAIL bp_ready_%0d got %b exp 0", k, rdy); end
            n_vec++; if ({out_valid, SrcA, SrcB, ALUCtrl, rd_addr} !== {1'b1, 32'd11, 32'd22, 4'b0000, 5'd7}) begin
                n_miss++; $display("FAIL bp_hold_%0d got v=%b %0d/%0d alu=%b rd=%0d exp 1 11/22 0000 7", k, out_valid, SrcA, SrcB, ALUCtrl, rd_addr);
            end
        end
        out_ready = 1'b1;
        exp_q.push_back(5'd8);
        drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd8, OP_R), 32'hA4, 32'd33, 32'd44, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL bp_release_ready got %b exp 1", rdy); end
        n_vec++; if ({rd_addr, ALUCtrl, SrcA} !== {5'd8, 4'b0001, 32'd33}) begin n_miss++; $display("FAIL bp_release got rd=%0d alu=%b a=%0d exp 8 0001 33", rd_addr, ALUCtrl, SrcA); end
        idle();
    endtask

    task automatic test_flush();
        logic rdy;
        out_ready = 1'b0;
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd9, OP_R), 32'hC0, 32'd1, 32'd1, rdy);
        n_vec++; if ({out_valid, rd_addr} !== {1'b1, 5'd9}) begin n_miss++; $display("FAIL fl_fill got v=%b rd=%0d exp 1 9", out_valid, rd_addr); end
        flush = 1'b1;
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd10, OP_R), 32'hC4, 32'd2, 32'd2, rdy);
        flush = 1'b0;
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL fl_ready got %b exp 1", rdy); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL fl_kill got %b exp 0", out_valid); end
        out_ready = 1'b1;
        idle();
        idle();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL fl_no_ghost got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic rdy;
        out_ready = 1'b1;
`ifdef ILLEGAL_INSN_EN
        exp_q.push_back(5'd3);
        drive(32'h0000_01FF, 32'hE0, 32'd5, 32'd6, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL ill_ready got %b exp 1", rdy); end
        n_vec++; if ({out_valid, illegal_instr, ALUCtrl, reg_write, mem_read, mem_write} !== {1'b1, 1'b1, 4'b0000, 3'b000}) begin
            n_miss++; $display("FAIL ill_flag got v=%b ill=%b alu=%b rw=%b mr=%b mw=%b exp 1 1 0000 0 0 0", out_valid, illegal_instr, ALUCtrl, reg_write, mem_read, mem_write);
        end
        flush = 1'b1;
        idle();
        flush = 1'b0;
        n_vec++; if ({out_valid, illegal_instr} !== 2'b00) begin n_miss++; $display("FAIL ill_flush got v=%b ill=%b exp 0 0", out_valid, illegal_instr); end
`else
        drive(32'h0000_01FF, 32'hE0, 32'd5, 32'd6, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_miss++; $display("FAIL ill_ready got %b exp 1", rdy); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL ill_bubble got %b exp 0", out_valid); end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_immediates();
        test_branch_store();
        test_load_use();
        test_backpressure();
        test_flush();
        test_illegal();
        idle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++; $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that sits in front of the ALU.
- Decodes a 32-bit RV32I instruction into ALUCtrl, picks the SrcA/SrcB operands (register, immediate, PC, zero or 4), and registers them.
- Register-file read addresses are driven combinationally; read data comes back in the same cycle.
- Output side uses a valid/ready handshake with EX, detects load-use hazards and inserts one bubble per hazard.

Parameters:
- W, 32, datapath width (operands, PC, immediates).
- RA, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction/PC available.
- in_ready  out  1  stage accepts instruction this cycle.
- instr  in  32  instruction word.
- pc  in  W  instruction address.
- rs1_addr  out  RA  combinational, instr[19:15].
- rs2_addr  out  RA  combinational, instr[24:20].
- rs1_data  in  W  register-file read data for rs1_addr.
- rs2_data  in  W  register-file read data for rs2_addr.
- flush  in  1  branch/jump redirect; kill stage contents.
- out_valid  out  1  registered; issue slot holds an instruction.
- out_ready  in  1  EX accepts issue slot.
- SrcA  out  W  registered ALU operand A.
- SrcB  out  W  registered ALU operand B.
- ALUCtrl  out  4  registered ALU op.
- rd_addr  out  RA  registered destination.
- reg_write  out  1  registered write-back enable.
- mem_read  out  1  registered load flag.
- mem_write  out  1  registered store flag.
- store_data  out  W  registered rs2_data.
- br_funct3  out  3  registered funct3.
- is_branch  out  1  registered branch flag.

Behaviour:
- ALUCtrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU.
  - Others reserved, never emitted.
- Decode, by opcode:
  - OP 0110011: SrcA=rs1, SrcB=rs2. funct7[5] selects SUB/SRA.
  - OP-IMM 0010011: SrcB=sign-extended I-imm. SRAI is selected by instr[30]. Shift amount is imm[4:0].
  - LUI: SrcA=0, SrcB=U-imm, ADD.
  - AUIPC: SrcA=pc, SrcB=U-imm, ADD.
  - LOAD/STORE: ADD with rs1 plus I/S-imm; mem_read/mem_write set.
  - BRANCH: BEQ/BNE=SUB, BLT/BGE=SLT, BLTU/BGEU=SLTU. is_branch=1, reg_write=0.
  - JAL/JALR: SrcA=pc, SrcB=4, ADD, reg_write=1 (link value).
- reg_write is forced 0 when rd=0.
- Unknown opcode → bubble (slot loads out_valid=0); in_ready=1.
- Load stall: a = out_valid & out_ready (slot drains this cycle); b = ~out_valid (slot empty).
- Slot loads when a or b holds.
- Load-use hazard: out_valid & mem_read & rd_addr≠0 & (rd_addr==rs1_addr used | rd_addr==rs2_addr used).
  - Hazard forces in_ready=0 and loads a bubble.
  - Next cycle the slot is empty, so the instruction issues. Exactly one bubble per hazard.
- in_ready = (~out_valid | out_ready) & ~hazard, or 1 during flush.
- Hold: out_valid & ~out_ready → all outputs stable, in_ready=0.
- flush (priority over everything except rst):
  - out_valid←0 next cycle.
  - A concurrent in_valid instruction is consumed and discarded.
- Reset: all outputs 0 (out_valid=0, ALUCtrl=0000). in_ready=0 while rst=1.
- Latency: one cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with no hazard.
- No internal memory of the register file.

Optional Feature:
- Macro: ILLEGAL_INSN_EN.
- Defined:
  - Adds output illegal_instr (1 bit, registered).
  - An unknown opcode sets illegal_instr=1 and out_valid=1 with ALUCtrl=0000, reg_write=0, mem_read=0, mem_write=0.
  - Cleared by flush or rst.
- Undefined: unknown opcodes become silent bubbles as above; no port added.

Decomposition:
- Shared package riscv_pkg:
  - alu_op_e enum (4-bit codes above).
  - opcode constants.
  - W default.
  - Immediate-type enum (I/S/B/U/J).
- Sub-module insn_decode: pure combinational decode of instr → alu_op, operand selects, imm, control flags.
- Sequential code (handshake, hazard, flush, pipeline register) stays in alu_issue_stage.

Test Plan:
- ADD reset: rst 2 cycles, then release → out_valid=0, in_ready=1, all outputs 0.
- ADD back-to-back:
  - Issue ADD x3,x1,x2 (rs1_data=5, rs2_data=7), out_ready=1.
  - Next cycle: SrcA=5, SrcB=7, ALUCtrl=0000, rd_addr=3, reg_write=1.
  - Follow with SUB: ALUCtrl=0001 one cycle later.
- Immediates:
  - ADDI x1,x0,-1 → SrcB=0xFFFFFFFF.
  - SRAI x2,x1,4 → ALUCtrl=0111, SrcB[4:0]=4.
  - LUI x5,0x12345 → SrcA=0, SrcB=0x12345000.
- Branch: BLTU x1,x2 → ALUCtrl=1001, is_branch=1, reg_write=0, br_funct3=110.
- Load-use:
  - LW x4,0(x1) followed by ADD x6,x4,x4 → one bubble (in_ready=0 one cycle).
  - ADD issues exactly two cycles after LW.
- Backpressure and flush:
  - out_ready=0 for 3 cycles → outputs stable, in_ready=0.
  - flush with in_valid=1 → next cycle out_valid=0 and the instruction never appears.
  - With ILLEGAL_INSN_EN: opcode 1111111 → illegal_instr=1.
